axi_tensor_wr_sink: RTL
=======================

Name: axi_tensor_wr_sink

Overview:
AXI4 write-slave that consumes the AW/W burst emitted by the tensor-core writeback master. It converts the burst into word writes on a single-port SRAM/DRAM-model write interface, buffering beats in a small FIFO to absorb memory stalls. It returns the B-channel response that the writeback path needs for completion. It is the stage directly downstream of the PE writeback engine.

Parameters:
ADDR_WIDTH, 32, AXI byte-address width
MEM_AW, 14, memory word-address width; word addr = byte addr >> 2, taken modulo 2^MEM_AW
FIFO_DEPTH, 4, W-beat buffer entries; power of two, ≥2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
axi_awaddr  in  ADDR_WIDTH  burst start byte address
axi_awlen  in  8  beats-1
axi_awsize  in  3  beat size; only 3'b010 (32-bit) legal
axi_awburst  in  2  only 2'b01 (INCR) legal
axi_awvalid  in  1  address valid
axi_awready  out  1  address accept
axi_wdata  in  32  beat data
axi_wvalid  in  1  data valid
axi_wready  out  1  data accept
axi_wlast  in  1  last beat marker
axi_bvalid  out  1  response valid
axi_bready  in  1  response accept
axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
mem_we  out  1  memory write request
mem_addr  out  MEM_AW  word address
mem_wdata  out  32  write data
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; FIFO flushed; beat counter=0; err=0.
  - Outputs during reset: awready=0, wready=0, bvalid=0, bresp=00, mem_we=0, busy=0.
  - Reset mid-burst abandons the burst: no B response, and no further mem_we from flushed entries.
- States: IDLE → DATA → DRAIN → RESP → IDLE.
- IDLE:
  - awready=1.
  - On awvalid&awready: latch word address awaddr[MEM_AW+1:2], beats_exp=awlen+1 (9-bit, range 1..256), clear beat counter.
  - Set err_cfg = (awsize≠010) | (awburst≠01) | (awaddr[1:0]≠0).
  - Go to DATA.
- DATA:
  - awready=0; wready = !fifo_full.
  - Each wvalid&wready is one accepted beat: if !err_cfg, push {wr_addr, wdata} and wr_addr += 1 (wraps at 2^MEM_AW). If err_cfg, the beat is consumed and discarded.
  - wlast check: wlast=1 on a beat other than beat beats_exp-1, or wlast=0 on that beat, sets err_last. This does not alter beat count or data.
  - On acceptance of beat beats_exp-1, go to DRAIN; wready drops the following cycle.
- DRAIN: wready=0. When FIFO is empty, go to RESP.
- RESP:
  - bvalid=1, bresp = (err_cfg|err_last) ? 10 : 00.
  - bvalid and bresp stay stable until bready.
  - On bvalid&bready, clear errors and go to IDLE. awready returns the next cycle; no back-to-back AW acceptance in the RESP cycle.
- FIFO drain, independent of state:
  - mem_we = !fifo_empty; mem_addr and mem_wdata come from the head entry.
  - Pop on mem_we&mem_ready.
  - mem_addr and mem_wdata hold stable while mem_we=1 and mem_ready=0.
- Latency: a beat accepted at edge N gives mem_we=1 in cycle N+1 at the earliest (registered FIFO). With mem_ready held at 1, throughput is one beat per cycle.
- Simultaneous push and pop: both happen, count unchanged. A push is blocked when full, because wready is low when full.
- W beats arriving in IDLE are not accepted (wready=0).
- Beat counter never exceeds beats_exp-1.

Decomposition:
- params package holds:
  - AXI_BURST_INCR=2'b01, AXI_SIZE_32=3'b010
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10
  - wr_sink_state_t enum {IDLE, DATA, DRAIN, RESP}
- Sub-module wr_sink_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Same clk and rst_n as the parent.

Test Plan:
- awaddr=0, awlen=255, size=010, burst=01, 256 beats of data i, wlast on beat 255, mem_ready=1 → mem writes to addr i with data i for i=0..255, one per cycle; bresp=00; busy falls after bready.
- awlen=127, mem_ready toggled 1/0 every cycle → wready drops when 4 entries are pending; all 128 writes land in order at addrs 0..127; bvalid only after the last mem_we&mem_ready.
- awlen=3, wlast asserted on beat 1 → all 4 beats written; bresp=10.
- awsize=001, awlen=7 → 8 beats accepted; mem_we never asserts; bresp=10.
- awaddr=0x0000FFFC with MEM_AW=14 → first write at word 0x3FFF, second wraps to 0x0000.
- rst_n pulled low after 10 beats of a 256-beat burst → all outputs at reset values within the same cycle; no bvalid; a fresh 4-beat burst afterwards gets bresp=00.

Source files
------------

// File: rtl/axi_tensor_wr_sink_pkg.sv
// Shared AXI encodings and FSM state type for the tensor-core writeback sink.
package axi_tensor_wr_sink_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_32     = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DRAIN,
        RESP
    } wr_sink_state_t;

    // A burst is only serviceable as aligned 32-bit INCR beats.
    function automatic logic aw_cfg_bad(input logic [2:0] size,
                                        input logic [1:0] burst,
                                        input logic [1:0] addr_lsb);
        return (size != AXI_SIZE_32) || (burst != AXI_BURST_INCR) || (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/wr_sink_fifo.sv
// Synchronous FIFO with registered storage; head entry is visible on dout whenever not empty.
module wr_sink_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] PtrOne = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW:0]    wptr_q, wptr_d;
    logic [PtrW:0]    rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PtrW-1:0]] <= din;
        end
    end

    assign dout = mem_q[rptr_q[PtrW-1:0]];

endmodule

// File: rtl/axi_tensor_wr_sink.sv
// AXI4 write slave: turns one AW/W burst into buffered word writes and returns a B response.
module axi_tensor_wr_sink
    import axi_tensor_wr_sink_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_AW     = 14,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [31:0]           axi_wdata,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic                  axi_wlast,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [1:0]            axi_bresp,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    localparam int unsigned EntryW = MEM_AW + 32;
    localparam logic [MEM_AW-1:0] AddrOne = 1;

    wr_sink_state_t    state_q, state_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        beats_exp_q, beats_exp_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              err_cfg_q, err_cfg_d;
    logic              err_last_q, err_last_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryW-1:0] fifo_din, fifo_dout;
    logic              w_hs, last_beat;
    logic              unused_awaddr_hi;

    assign unused_awaddr_hi = ^axi_awaddr[ADDR_WIDTH-1:MEM_AW+2];

    // awready is gated by rst_n so it reads low while reset is held, not just after it.
    assign axi_awready = rst_n && (state_q == IDLE);
    assign axi_wready  = (state_q == DATA) && !fifo_full;
    assign axi_bvalid  = (state_q == RESP);
    assign axi_bresp   = (axi_bvalid && (err_cfg_q || err_last_q)) ? AXI_RESP_SLVERR
                                                                  : AXI_RESP_OKAY;
    assign busy        = (state_q != IDLE);

    assign w_hs      = axi_wvalid && axi_wready;
    assign last_beat = (({1'b0, beat_cnt_q} + 9'd1) == beats_exp_q);

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        beats_exp_d = beats_exp_q;
        beat_cnt_d  = beat_cnt_q;
        err_cfg_d   = err_cfg_q;
        err_last_d  = err_last_q;
        fifo_push   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (axi_awvalid && axi_awready) begin
                    wr_addr_d   = axi_awaddr[MEM_AW+1:2];
                    beats_exp_d = {1'b0, axi_awlen} + 9'd1;
                    beat_cnt_d  = '0;
                    err_cfg_d   = aw_cfg_bad(axi_awsize, axi_awburst, axi_awaddr[1:0]);
                    err_last_d  = 1'b0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    // Misconfigured bursts are still consumed beat by beat, just never written.
                    if (!err_cfg_q) begin
                        fifo_push = 1'b1;
                        wr_addr_d = wr_addr_q + AddrOne;
                    end
                    if (axi_wlast != last_beat) begin
                        err_last_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (axi_bready) begin
                    err_cfg_d  = 1'b0;
                    err_last_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            beats_exp_q <= '0;
            beat_cnt_q  <= '0;
            err_cfg_q   <= 1'b0;
            err_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            beats_exp_q <= beats_exp_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cfg_q   <= err_cfg_d;
            err_last_q  <= err_last_d;
        end
    end

    assign fifo_din = {wr_addr_q, axi_wdata};
    assign fifo_pop = mem_we && mem_ready;

    wr_sink_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mem_we    = !fifo_empty;
    assign mem_addr  = fifo_dout[EntryW-1:32];
    assign mem_wdata = fifo_dout[31:0];

endmodule
